// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator/checker: one MSB-first division step per clock,
// valid/ready on both sides, result held in DONE until the consumer takes it.
module crc_serial_engine #(
  parameter int                 DATA_W = 8,
  parameter int                 CRC_W  = 3,
  parameter logic [CRC_W-1:0]   POLY   = 3'b011
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mode,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [CRC_W-1:0]          in_crc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CRC_W-1:0]          out_crc,
  output logic [DATA_W+CRC_W-1:0]   out_code,
  output logic                      out_err,
  output logic                      out_mode
);

  localparam int CODE_W = DATA_W + CRC_W;
  localparam int CNT_W  = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CRC_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   shreg_q, shreg_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                mode_q, mode_d;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [CRC_W-1:0]    res_crc_q, res_crc_d;
  logic [CODE_W-1:0]   res_code_q, res_code_d;
  logic                res_err_q, res_err_d;
  logic                res_mode_q, res_mode_d;

  // One division step: shift the remainder, fold in the generator when the
  // outgoing remainder bit differs from the incoming message bit.
  logic                fb;
  logic [CRC_W-1:0]    rem_shl;
  logic [CRC_W-1:0]    rem_step;

  assign fb      = rem_q[CRC_W-1] ^ shreg_q[CODE_W-1];
  assign rem_shl = {rem_q[CRC_W-2:0], 1'b0};

  generate
    for (genvar gi = 0; gi < CRC_W; gi++) begin : g_step
      assign rem_step[gi] = rem_shl[gi] ^ (fb & POLY[gi]);
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    code_d     = code_q;
    mode_d     = mode_q;
    res_crc_d  = res_crc_q;
    res_code_d = res_code_q;
    res_err_d  = res_err_q;
    res_mode_d = res_mode_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          code_d  = {in_data, (in_mode ? in_crc : {CRC_W{1'b0}})};
          shreg_d = {in_data, (in_mode ? in_crc : {CRC_W{1'b0}})};
          rem_d   = '0;
          mode_d  = in_mode;
          cnt_d   = in_mode ? CNT_W'(CODE_W - 1) : CNT_W'(DATA_W - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        rem_d   = rem_step;
        shreg_d = {shreg_q[CODE_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d    = ST_DONE;
          res_crc_d  = rem_step;
          res_code_d = mode_q ? code_q : {code_q[CODE_W-1:CRC_W], rem_step};
          res_err_d  = mode_q & (|rem_step);
          res_mode_d = mode_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      code_q      <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_crc_q   <= '0;
      res_code_q  <= '0;
      res_err_q   <= 1'b0;
      res_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      code_q      <= code_d;
      mode_q      <= mode_d;
      // Handshake flags track the state being entered so they are glitch-free.
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      res_crc_q   <= res_crc_d;
      res_code_q  <= res_code_d;
      res_err_q   <= res_err_d;
      res_mode_q  <= res_mode_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_crc   = res_crc_q;
  assign out_code  = res_code_q;
  assign out_err   = res_err_q;
  assign out_mode  = res_mode_q;

endmodule
